// File: rtl/ms_uart_pkg.sv
// Shared widths and defaults for the UART receive path.
// MS_UART_RX_FIFO_ERR_EN widens FIFO entries to carry the per-byte parity flag.
package ms_uart_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned FIFO_DEPTH    = 8;
  localparam int unsigned FIFO_ADDR_W   = 3;
  localparam int unsigned ENTRY_W_ERR   = BYTE_W + 1;
  localparam int unsigned ENTRY_W_NOERR = BYTE_W;

`ifdef MS_UART_RX_FIFO_ERR_EN
  localparam int unsigned ENTRY_W = ENTRY_W_ERR;
`else
  localparam int unsigned ENTRY_W = ENTRY_W_NOERR;
`endif

endpackage

// File: rtl/ms_uart_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module ms_uart_fifo_mem #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned WIDTH  = 8
) (
  input  logic              internalclk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge internalclk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ms_uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: one push per DONE rising edge, FWFT read port.
// MS_UART_RX_FIFO_ERR_EN stores RX_ERR per byte and reports it on DOUT_ERR.
module ms_uart_rx_fifo
  import ms_uart_pkg::*;
#(
  parameter int unsigned DEPTH  = FIFO_DEPTH,
  parameter int unsigned ADDR_W = FIFO_ADDR_W
) (
  input  logic            CLK,
  input  logic            RESETN,
  input  logic [7:0]      RX_DATA,
  input  logic            RX_DONE,
  input  logic            RX_ERR,
  input  logic            RD_EN,
  input  logic            CLR_OVF,
  output logic [7:0]      DOUT,
  output logic            DOUT_ERR,
  output logic            EMPTY,
  output logic            FULL,
  output logic [ADDR_W:0] COUNT,
  output logic            OVERFLOW
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic               done_q;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count;
  logic               overflow;
  logic               push;
  logic               push_ok;
  logic               pop_ok;
  logic               ovf_set;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign EMPTY = (count == '0);
  assign FULL  = (count == CNT_FULL);

  // A pop frees the slot in the same cycle, so a push into a full FIFO is accepted alongside it.
  assign push    = RX_DONE & ~done_q;
  assign pop_ok  = RD_EN & ~EMPTY;
  assign push_ok = push & (~FULL | pop_ok);
  assign ovf_set = push & FULL & ~pop_ok;

`ifdef MS_UART_RX_FIFO_ERR_EN
  assign wr_entry = {RX_ERR, RX_DATA};
  assign DOUT_ERR = ~EMPTY & rd_entry[BYTE_W];
`else
  logic unused_rx_err;
  assign unused_rx_err = RX_ERR;
  assign wr_entry      = RX_DATA;
  assign DOUT_ERR      = 1'b0;
`endif

  assign DOUT     = EMPTY ? '0 : rd_entry[BYTE_W-1:0];
  assign COUNT    = count;
  assign OVERFLOW = overflow;

  always_ff @(posedge CLK) begin
    if (RESETN) begin
      done_q   <= 1'b1;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= RX_DONE;
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (CLR_OVF) overflow <= 1'b0;
    end
  end

  ms_uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_mem (
    .internalclk (CLK),
    .wr_en       (push_ok),
    .wr_addr     (wr_ptr),
    .wr_data     (wr_entry),
    .rd_addr     (rd_ptr),
    .rd_data     (rd_entry)
  );

endmodule

// File: tb/tb_ms_uart_rx_fifo.sv
// Scoreboard bench for ms_uart_rx_fifo: accepted frames are queued, a monitor checks each pop.
module tb_ms_uart_rx_fifo;

`ifdef MS_UART_RX_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESETN = 1'b1;
  logic [7:0] RX_DATA = '0;
  logic       RX_DONE = 1'b0;
  logic       RX_ERR = 1'b0;
  logic       RD_EN = 1'b0;
  logic       CLR_OVF = 1'b0;
  logic [7:0] DOUT;
  logic       DOUT_ERR;
  logic       EMPTY;
  logic       FULL;
  logic [3:0] COUNT;
  logic       OVERFLOW;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];

  always #5 CLK = ~CLK;

  ms_uart_rx_fifo #(
    .DEPTH  (8),
    .ADDR_W (3)
  ) dut (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .RX_DATA  (RX_DATA),
    .RX_DONE  (RX_DONE),
    .RX_ERR   (RX_ERR),
    .RD_EN    (RD_EN),
    .CLR_OVF  (CLR_OVF),
    .DOUT     (DOUT),
    .DOUT_ERR (DOUT_ERR),
    .EMPTY    (EMPTY),
    .FULL     (FULL),
    .COUNT    (COUNT),
    .OVERFLOW (OVERFLOW)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT pops, the head must match the oldest queued frame.
  always @(negedge CLK) begin
    if (!RESETN && RD_EN && !EMPTY) begin
      logic [8:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL pop_unexpected: got %0h expected no entry", DOUT);
      end else begin
        e = exp_q.pop_front();
        if (DOUT !== e[7:0] || DOUT_ERR !== e[8]) begin
          n_errors++;
          $display("FAIL pop_data: got %0h/%0b expected %0h/%0b", DOUT, DOUT_ERR, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic expect_push(input logic [7:0] d, input logic e);
    exp_q.push_back({e & ERR_EN, d});
  endtask

  // DONE high one cycle then low one cycle; returns just after the DONE-low edge.
  task automatic send_byte(input logic [7:0] d, input logic e, input bit accept);
    @(posedge CLK); #1;
    RX_DATA = d; RX_ERR = e; RX_DONE = 1'b1;
    if (accept) expect_push(d, e);
    @(posedge CLK); #1;
    RX_DONE = 1'b0;
  endtask

  task automatic pop(input int n);
    @(posedge CLK); #1;
    RD_EN = 1'b1;
    repeat (n) @(posedge CLK);
    #1 RD_EN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst_count", 32'(COUNT), 0);
    check("rst_empty", 32'(EMPTY), 1);
    check("rst_full", 32'(FULL), 0);
    check("rst_ovf", 32'(OVERFLOW), 0);
    check("rst_dout", 32'(DOUT), 0);
    check("rst_dout_err", 32'(DOUT_ERR), 0);
    RESETN = 1'b0;
    @(posedge CLK); #1;

    // Long DONE pulse yields exactly one push.
    RX_DATA = 8'hA5; RX_ERR = 1'b0; RX_DONE = 1'b1;
    expect_push(8'hA5, 1'b0);
    @(posedge CLK); #1;
    check("single_count", 32'(COUNT), 1);
    check("single_dout", 32'(DOUT), 32'hA5);
    check("single_empty", 32'(EMPTY), 0);
    repeat (39) @(posedge CLK);
    #1 RX_DONE = 1'b0;
    check("single_count_hold", 32'(COUNT), 1);
    pop(1);
    check("single_pop_empty", 32'(EMPTY), 1);
    check("single_pop_dout", 32'(DOUT), 0);

    // Fill, partial drain, wrap.
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0, 1'b1);
    check("fill_full", 32'(FULL), 1);
    check("fill_count", 32'(COUNT), 8);
    pop(3);
    check("wrap_count3", 32'(COUNT), 5);
    for (int i = 9; i <= 11; i++) send_byte(8'(i), 1'b0, 1'b1);
    check("wrap_full", 32'(FULL), 1);

    // Overflow drop, clear, and set-beats-clear.
    send_byte(8'hFF, 1'b0, 1'b0);
    check("ovf_set", 32'(OVERFLOW), 1);
    check("ovf_count", 32'(COUNT), 8);
    @(posedge CLK); #1 CLR_OVF = 1'b1;
    @(posedge CLK); #1 CLR_OVF = 1'b0;
    check("ovf_clear", 32'(OVERFLOW), 0);
    RX_DATA = 8'hFE; RX_DONE = 1'b1; CLR_OVF = 1'b1;
    @(posedge CLK); #1 RX_DONE = 1'b0; CLR_OVF = 1'b0;
    check("ovf_set_wins", 32'(OVERFLOW), 1);
    @(posedge CLK); #1 CLR_OVF = 1'b1;
    @(posedge CLK); #1 CLR_OVF = 1'b0;
    check("ovf_clear2", 32'(OVERFLOW), 0);

    // Push and pop together while full.
    RX_DATA = 8'h0C; RX_ERR = 1'b0; RX_DONE = 1'b1; RD_EN = 1'b1;
    expect_push(8'h0C, 1'b0);
    @(posedge CLK); #1 RX_DONE = 1'b0; RD_EN = 1'b0;
    check("simul_full_count", 32'(COUNT), 8);
    check("simul_full_ovf", 32'(OVERFLOW), 0);
    pop(8);
    check("drain_empty", 32'(EMPTY), 1);

    // Push and pop together while empty: pop ignored.
    @(posedge CLK); #1;
    RX_DATA = 8'h5A; RX_DONE = 1'b1; RD_EN = 1'b1;
    expect_push(8'h5A, 1'b0);
    @(posedge CLK); #1 RX_DONE = 1'b0; RD_EN = 1'b0;
    check("simul_empty_count", 32'(COUNT), 1);
    check("simul_empty_dout", 32'(DOUT), 32'h5A);
    pop(1);

    // Reset mid-operation with DONE rising in the reset cycle and held afterwards.
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b0, 1'b1);
    check("pre_rst_count", 32'(COUNT), 5);
    @(posedge CLK); #1;
    RX_DATA = 8'h77; RX_DONE = 1'b1; RESETN = 1'b1;
    @(posedge CLK); #1 RESETN = 1'b0;
    exp_q.delete();
    check("midrst_count", 32'(COUNT), 0);
    check("midrst_empty", 32'(EMPTY), 1);
    check("midrst_ovf", 32'(OVERFLOW), 0);
    check("midrst_dout", 32'(DOUT), 0);
    repeat (3) @(posedge CLK);
    #1 RX_DONE = 1'b0;
    check("post_rst_no_push", 32'(COUNT), 0);

    // Parity flag per entry.
    send_byte(8'h3C, 1'b1, 1'b1);
    check("err_head_flag", 32'(DOUT_ERR), 32'(ERR_EN));
    send_byte(8'h3D, 1'b0, 1'b1);
    pop(2);
    check("err_drained", 32'(EMPTY), 1);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ms_uart_rx_fifo.md
# ms_uart_rx_fifo

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each completed frame, signalled by the rising edge of the receiver's DONE, into a small circular FIFO in the board-clock domain. It then presents the bytes to the host logic through a first-word-fall-through read port with full, empty, count and sticky-overflow status.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, 2..64.
- ADDR_W, 3: log2(DEPTH); pointer width; COUNT is ADDR_W+1 bits.

Ports:
- CLK  in  1  board clock; the only clock.
- RESETN  in  1  reset, synchronous, active-high (the name is historical; high = reset).
- RX_DATA  in  8  received byte from the UART receiver; stable while RX_DONE is high.
- RX_DONE  in  1  receiver frame-complete flag; level, high for ≥1 CLK.
- RX_ERR  in  1  receiver parity-error flag, qualified by RX_DONE.
- RD_EN  in  1  pop request for the head entry.
- CLR_OVF  in  1  clears OVERFLOW.
- DOUT  out  8  head entry (fall-through); 8'h00 when EMPTY.
- DOUT_ERR  out  1  parity flag of the head entry; 0 when EMPTY.
- EMPTY  out  1  no entries.
- FULL  out  1  COUNT == DEPTH.
- COUNT  out  ADDR_W+1  occupancy, 0..DEPTH.
- OVERFLOW  out  1  sticky: a frame was dropped because the FIFO was full.

## Operation
- Edge detect: `done_q` registers RX_DONE every CLK. `push = RX_DONE & ~done_q`, giving exactly one push per frame regardless of how long DONE stays high.
- Write: on push with ~FULL (or FULL with an accepted pop in the same cycle), store {RX_ERR, RX_DATA} at `wr_ptr`; then `wr_ptr` +1, wrapping modulo DEPTH.
- Read: on RD_EN & ~EMPTY, `rd_ptr` +1, wrapping modulo DEPTH. RD_EN while EMPTY is ignored; there is no underflow flag.
- COUNT: +1 on an accepted push only, −1 on an accepted pop only, unchanged when both or neither occur.
- FULL/EMPTY: decoded from COUNT, never from pointer equality.
- Simultaneous push and pop:
  - EMPTY: push accepted, pop ignored; COUNT becomes 1.
  - FULL: both accepted; COUNT stays DEPTH; no overflow.
  - Otherwise: both accepted.
- Overflow: push while FULL without a pop drops the byte. Stored data and pointers are unchanged. OVERFLOW is set.
- OVERFLOW clearing: CLR_OVF clears it. If a set and a clear occur in the same cycle, the set wins.
- Reset (any cycle, including mid-frame or while full): pointers, COUNT and OVERFLOW go to 0; EMPTY=1, FULL=0, DOUT=0, DOUT_ERR=0. `done_q` resets to 1, so a DONE still high from before reset does not create a spurious push. Memory contents are not cleared.

## Timing
- Push latency: RX_DONE rises in cycle N → entry written and COUNT/EMPTY updated at edge N+1 → DOUT valid in cycle N+1.
- Pop: RD_EN sampled at edge K → DOUT shows the next entry (or 0 with EMPTY=1) in cycle K+1.
- All outputs are registered or decoded from registers only. No combinational path from RD_EN to DOUT/EMPTY/FULL.
- Minimum RX_DONE low time between frames: 1 CLK.

## Configuration
- Macro: `MS_UART_RX_FIFO_ERR_EN`.
- Defined: entries are 9 bits. RX_ERR is stored per byte and DOUT_ERR reports the head's flag.
- Undefined: entries are 8 bits. RX_ERR is unused and DOUT_ERR is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `ms_uart_pkg`: byte width (8), default FIFO depth, entry width with and without the error flag.
- One sub-module, `ms_uart_fifo_mem`: DEPTH × entry-width register array with one synchronous write port and one asynchronous read port.
- Control (edge detect, pointers, COUNT, flags) stays in the top module.

## Test plan
- Single frame: RX_DATA=8'hA5, RX_DONE high for 40 CLK → exactly one push; COUNT=1, DOUT=8'hA5, EMPTY=0 one cycle after the edge. RD_EN for 1 cycle → EMPTY=1, DOUT=0.
- Fill and wrap: push 8'h01..8'h08 → FULL=1, COUNT=8. Pop 3, push 8'h09..8'h0B → pops return 01..08, then 09..0B, in order.
- Overflow: with FULL, push 8'hFF → OVERFLOW=1, COUNT=8, 8'hFF never read out. CLR_OVF → OVERFLOW=0. CLR_OVF together with another dropped push → OVERFLOW=1.
- Simultaneous events: with FULL, push and RD_EN in the same cycle → COUNT=8, OVERFLOW=0. With EMPTY, push and RD_EN in the same cycle → COUNT=1.
- Reset mid-operation: COUNT=5, RESETN high for 1 cycle while RX_DONE=1 → COUNT=0, EMPTY=1, OVERFLOW=0, and no push when RESETN drops while RX_DONE is still high.
- Error flag (with the macro): push 8'h3C with RX_ERR=1, then 8'h3D with RX_ERR=0 → DOUT_ERR reads 1 then 0. Without the macro, DOUT_ERR=0 throughout.
